// File: rtl/key_entry_buf.sv
// ============================================================================
//  Module      : key_entry_buf
//  Description : Keypad entry buffer. Collects decimal digits from the 4x4
//                keypad scanner into a shift buffer, with backspace, clear,
//                enter (commit) and an inactivity timeout that discards a
//                partially typed entry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_entry_buf #(
    parameter int DIGITS      = 4,
    parameter int TIMEOUT_CYC = 250_000_000,
    parameter int CNT_W       = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            key_in,
    input  logic                  key_vld,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic [2:0]            digit_cnt,
    output logic [4*DIGITS-1:0]   entry_bcd,
    output logic                  entry_vld,
    output logic                  key_err,
    output logic                  timeout
);

    localparam int               c_BW   = 4 * DIGITS;
    localparam logic [2:0]       c_FULL = 3'(DIGITS);
    localparam logic [CNT_W-1:0] c_TERM = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTRY  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [c_BW-1:0]  r_buf,   w_buf_nxt;
    logic [c_BW-1:0]  r_entry, w_entry_nxt;
    logic [2:0]       r_cnt,   w_cnt_nxt;
    logic [CNT_W-1:0] r_tmr,   w_tmr_nxt;
    logic             r_err,   w_err_nxt;
    logic             r_vld,   w_vld_nxt;
    logic             r_to,    w_to_nxt;

    // Register all state and pulse outputs; reset clears everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_entry <= '0;
            r_cnt   <= 3'd0;
            r_tmr   <= '0;
            r_err   <= 1'b0;
            r_vld   <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_entry <= w_entry_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmr   <= w_tmr_nxt;
            r_err   <= w_err_nxt;
            r_vld   <= w_vld_nxt;
            r_to    <= w_to_nxt;
        end
    end

    // Key decode, buffer edits, timeout tracking and next-state selection
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_entry_nxt = r_entry;
        w_cnt_nxt   = r_cnt;
        w_tmr_nxt   = '0;
        w_err_nxt   = 1'b0;
        w_vld_nxt   = 1'b0;
        w_to_nxt    = 1'b0;

        case (r_state)
            // One-cycle commit strobe; any key arriving here is ignored
            S_COMMIT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                if (key_vld) begin
                    // Any key (even a no-op) restarts the inactivity timer
                    if (key_in <= 4'd9) begin
                        if (r_cnt != c_FULL) begin
                            w_buf_nxt   = (r_buf << 4) | c_BW'(key_in);
                            w_cnt_nxt   = r_cnt + 3'd1;
                            w_state_nxt = S_ENTRY;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        case (key_in)
                            4'hA: begin
                                if (r_cnt != 3'd0) begin
                                    w_buf_nxt = r_buf >> 4;
                                    w_cnt_nxt = r_cnt - 3'd1;
                                    if (r_cnt == 3'd1) begin
                                        w_state_nxt = S_IDLE;
                                    end
                                end else begin
                                    w_err_nxt = 1'b1;
                                end
                            end
                            4'hB: begin
                                w_buf_nxt   = '0;
                                w_cnt_nxt   = 3'd0;
                                w_state_nxt = S_IDLE;
                            end
                            4'hC: begin
                                if (r_cnt != 3'd0) begin
                                    w_entry_nxt = r_buf;
                                    w_buf_nxt   = '0;
                                    w_cnt_nxt   = 3'd0;
                                    w_vld_nxt   = 1'b1;
                                    w_state_nxt = S_COMMIT;
                                end else begin
                                    w_err_nxt = 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end else if (r_state == S_ENTRY) begin
                    // Idle while digits are pending: count toward discard
                    if (r_tmr == c_TERM) begin
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = 3'd0;
                        w_to_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_tmr_nxt = r_tmr + c_ONE;
                    end
                end
            end
        endcase
    end

    assign disp_bcd  = r_buf;
    assign digit_cnt = r_cnt;
    assign entry_bcd = r_entry;
    assign entry_vld = r_vld;
    assign key_err   = r_err;
    assign timeout   = r_to;

endmodule

`default_nettype wire
